// File: rtl/keypad_scan.sv
// keypad_scan: scans a 4x4 hex matrix keypad, debounces one key at a time and emits one code per press.
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   row_in    keypad rows, active-low, asynchronous (externally pulled high)
//   clr       synchronous clear of the entry register
//   col_out   column strobes, active-low, one bit low at a time
//   key_valid one-cycle pulse per accepted press
//   key_code  hex code of the last accepted key, held between presses
//   value     32-bit entry register, newest digit in [3:0]
//
// Build option: define KEYPAD_ENTRY_EN to build the value shift register and clr handling;
// otherwise value is tied to zero and clr is ignored.
module keypad_scan #(
    parameter int SCAN_DIV     = 100000,
    parameter int DEBOUNCE_CNT = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row_in,
    input  logic        clr,
    output logic [3:0]  col_out,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [31:0] value
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    // nibble {row, col} of this constant is the key printed at that position
    localparam logic [63:0] KEYMAP = 64'hDEF0_C987_B654_A321;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

    state_t         state;
    logic [3:0]     s1, rs;
    logic [DW-1:0]  dwell;
    logic [1:0]     c, lr;
    logic [CW-1:0]  mcnt, rcnt;
    logic [3:0]     low;
    logic           hit, sample, accept;
    logic [1:0]     row_idx;
    logic [3:0]     code;

    always_comb begin
        low     = ~rs;
        hit     = (low != 4'd0) && ((low & (low - 4'd1)) == 4'd0);
        row_idx = {low[3] | low[2], low[3] | low[1]};
        sample  = dwell == DW'(SCAN_DIV - 1);
        code    = KEYMAP[{row_idx, c, 2'b00} +: 4];
        // the sample completing DEBOUNCE_CNT matches; with a count of 1 the first hit in SCAN is enough
        accept  = sample && hit &&
                  ((state == SCAN && DEBOUNCE_CNT == 1) ||
                   (state == DEBOUNCE && row_idx == lr && mcnt == CW'(DEBOUNCE_CNT - 1)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SCAN;
            s1        <= 4'hF;
            rs        <= 4'hF;
            dwell     <= '0;
            c         <= 2'd0;
            col_out   <= 4'b1110;
            lr        <= 2'd0;
            mcnt      <= '0;
            rcnt      <= '0;
            key_valid <= 1'b0;
            key_code  <= 4'h0;
        end else begin
            s1        <= row_in;
            rs        <= s1;
            dwell     <= sample ? '0 : dwell + 1'b1;
            key_valid <= accept;
            if (accept)
                key_code <= code;
            if (sample) begin
                case (state)
                    SCAN: begin
                        if (hit) begin
                            lr    <= row_idx;
                            mcnt  <= CW'(1);
                            rcnt  <= '0;
                            state <= accept ? HELD : DEBOUNCE;
                        end else begin
                            c       <= c + 2'd1;
                            col_out <= {col_out[2:0], col_out[3]};
                        end
                    end
                    DEBOUNCE: begin
                        if (hit && row_idx == lr) begin
                            mcnt <= mcnt + 1'b1;
                            if (accept) begin
                                state <= HELD;
                                rcnt  <= '0;
                            end
                        end else begin
                            state   <= SCAN;
                            c       <= c + 2'd1;
                            col_out <= {col_out[2:0], col_out[3]};
                        end
                    end
                    HELD: begin
                        if (hit)
                            rcnt <= '0;
                        else if (rcnt == CW'(DEBOUNCE_CNT - 1)) begin
                            rcnt    <= '0;
                            state   <= SCAN;
                            c       <= c + 2'd1;
                            col_out <= {col_out[2:0], col_out[3]};
                        end else
                            rcnt <= rcnt + 1'b1;
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

`ifdef KEYPAD_ENTRY_EN
    always_ff @(posedge clk) begin
        if (rst)
            value <= 32'h0;
        else if (clr)
            value <= accept ? {28'h0, code} : 32'h0;
        else if (accept)
            value <= {value[27:0], code};
    end
`else
    logic unused_clr;
    assign unused_clr = clr;
    assign value      = 32'h0;
`endif

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: randomized and directed keypad presses checked cycle by cycle against a reference model.
module tb_keypad_scan;
    localparam int SD = 4;
    localparam int DB = 3;
`ifdef KEYPAD_ENTRY_EN
    localparam bit ENTRY = 1'b1;
`else
    localparam bit ENTRY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, clr;
    logic [3:0]  row_in, col_out, key_code;
    logic        key_valid;
    logic [31:0] value;
    logic [15:0] key_mask;

    int n_checks = 0;
    int n_errors = 0;
    int dut_pulses = 0;

    int keymap [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{0, 15, 14, 13}};

    int          e, mcol, lock_row, run, quiet;
    bit          held;
    logic [3:0]  d1, d2, exp_code;
    logic        exp_valid;
    logic [31:0] exp_value;

    always #5 clk = ~clk;

    keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
        .clk(clk), .rst(rst), .row_in(row_in), .clr(clr),
        .col_out(col_out), .key_valid(key_valid), .key_code(key_code), .value(value)
    );

    // physical keypad: a row reads low when a pressed key joins it to the strobed column
    always_comb
        for (int r = 0; r < 4; r++)
            row_in[r] = ~|(key_mask[r*4 +: 4] & ~col_out);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_accept();
        exp_valid = 1'b1;
        exp_code  = 4'(keymap[lock_row][mcol]);
        if (ENTRY)
            exp_value = {exp_value[27:0], exp_code};
        held  = 1'b1;
        quiet = 0;
    endtask

    task automatic model_step();
        logic [3:0] raw, rsv, lw;
        int r;
        for (int i = 0; i < 4; i++)
            raw[i] = !key_mask[i*4 + mcol];
        if (rst) begin
            e = 0; mcol = 0; lock_row = -1; run = 0; quiet = 0; held = 1'b0;
            d1 = 4'hF; d2 = 4'hF;
            exp_valid = 1'b0; exp_code = 4'h0; exp_value = 32'h0;
            return;
        end
        rsv = d2; d2 = d1; d1 = raw;
        exp_valid = 1'b0;
        if (e % SD == SD - 1) begin
            lw = ~rsv;
            r  = -1;
            if ($countones(lw) == 1)
                for (int i = 0; i < 4; i++)
                    if (lw[i]) r = i;
            if (held) begin
                quiet = (r >= 0) ? 0 : quiet + 1;
                if (quiet == DB) begin
                    held = 1'b0; lock_row = -1; mcol = (mcol + 1) % 4;
                end
            end else if (lock_row < 0) begin
                if (r >= 0) begin
                    lock_row = r; run = 1;
                    if (run == DB) do_accept();
                end else
                    mcol = (mcol + 1) % 4;
            end else if (r == lock_row) begin
                run++;
                if (run == DB) do_accept();
            end else begin
                lock_row = -1; mcol = (mcol + 1) % 4;
            end
        end
        e++;
        if (ENTRY && clr)
            exp_value = exp_valid ? {28'h0, exp_code} : 32'h0;
    endtask

    task automatic tick();
        logic [3:0] ecol;
        @(posedge clk);
        model_step();
        @(negedge clk);
        ecol = ~(4'b0001 << mcol);
        if (key_valid === 1'b1) dut_pulses++;
        check("col", 32'(col_out), 32'(ecol));
        check("valid", 32'(key_valid), 32'(exp_valid));
        check("code", 32'(key_code), 32'(exp_code));
        check("value", value, exp_value);
    endtask

    function automatic logic [15:0] key_bit(input int code);
        logic [15:0] m = 16'h0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keymap[r][c] == code) m = 16'h1 << (r*4 + c);
        return m;
    endfunction

    task automatic press(input int code, input int hold, input int rel, input bit rclr);
        key_mask = key_bit(code);
        for (int i = 0; i < hold + rel; i++) begin
            if (i == hold) key_mask = 16'h0;
            clr = rclr && ($urandom_range(0, 24) == 0);
            tick();
        end
        clr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        bit found;
        int seq [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 10};
        rst = 1'b1; clr = 1'b0; key_mask = 16'h0;
        repeat (3) tick();
        check("rst_col", 32'(col_out), 32'hE);
        check("rst_valid", 32'(key_valid), 32'h0);
        check("rst_code", 32'(key_code), 32'h0);
        check("rst_value", value, 32'h0);
        rst = 1'b0;

        p0 = dut_pulses;
        repeat (64) tick();
        check("idle_pulses", 32'(dut_pulses - p0), 32'h0);
        check("idle_value", value, 32'h0);

        p0 = dut_pulses;
        press(5, 80, 40, 1'b0);
        check("press5_pulses", 32'(dut_pulses - p0), 32'h1);
        check("press5_code", 32'(key_code), 32'h5);
        check("press5_value", value, ENTRY ? 32'h5 : 32'h0);

        p0 = dut_pulses;
        for (int i = 0; i < 40; i++) begin
            key_mask = ((i / 3) % 2 == 0) ? key_bit(9) : 16'h0;
            tick();
        end
        press(9, 60, 40, 1'b0);
        check("bounce_pulses", 32'(dut_pulses - p0), 32'h1);
        check("bounce_code", 32'(key_code), 32'h9);

        p0 = dut_pulses;
        foreach (seq[i]) press(seq[i], 60, 30, 1'b0);
        check("ovf_pulses", 32'(dut_pulses - p0), 32'h9);
        check("ovf_value", value, ENTRY ? 32'h2345_678A : 32'h0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_value", value, 32'h0);

        key_mask = key_bit(15);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (lock_row >= 0 && !held && run == DB - 1 && e % SD == SD - 1) found = 1'b1;
        end
        check("clr_acc_wait", 32'(found), 32'h1);
        if (found) begin
            clr = 1'b1;
            tick();
            clr = 1'b0;
            check("clr_acc_valid", 32'(key_valid), 32'h1);
            check("clr_acc_code", 32'(key_code), 32'hF);
            check("clr_acc_value", value, ENTRY ? 32'hF : 32'h0);
        end
        key_mask = 16'h0;
        repeat (40) tick();

        p0 = dut_pulses;
        key_mask = key_bit(1) | key_bit(7);
        repeat (60) tick();
        key_mask = 16'h0;
        repeat (30) tick();
        check("multi_pulses", 32'(dut_pulses - p0), 32'h0);

        key_mask = key_bit(5);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (lock_row >= 0 && !held) found = 1'b1;
        end
        check("rst_deb_wait", 32'(found), 32'h1);
        p0 = dut_pulses;
        rst = 1'b1;
        key_mask = 16'h0;
        tick();
        check("rst_deb_col", 32'(col_out), 32'hE);
        rst = 1'b0;
        repeat (40) tick();
        check("rst_deb_pulses", 32'(dut_pulses - p0), 32'h0);

        p0 = dut_pulses;
        for (int k = 0; k < 20; k++)
            press(int'($urandom_range(0, 15)), int'($urandom_range(50, 90)), int'($urandom_range(30, 50)), 1'b1);
        check("rand_pulses", 32'(dut_pulses - p0), 32'd20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
